// File: rtl/seg7_scan.sv
// Scans up to 8 hex digits onto a multiplexed 7-segment display, one digit per scan_clk rise.
// Latency: a scan_clk rise sampled on clk_ edge N is visible on an/seg/seg_dp at edge N+2.
// Backpressure: none; en=0 blanks the anodes and freezes the digit index and frame shadow.
module seg7_scan #(
    parameter int DIGITS     = 8,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk_,
    input  logic        rst_n,
    input  logic        scan_clk,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic        frame_done
);

    // Inactive levels depend on the board's driver polarity.
    localparam logic [7:0] AN_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;
    localparam logic [2:0] IDX_MAX = 3'(DIGITS - 1);

    logic        s1_q, s2_q, s3_q;
    logic        tick;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] shadow_q;
    logic [7:0]  dp_sh_q;
    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic        seg_dp_q;
    logic        frame_done_q;

    logic [31:0] nib_src;
    logic [7:0]  dp_src;
    logic [3:0]  nib;
    logic        dp_bit;
    logic [7:0]  lz;
    logic        acc;
    logic        blank;
    logic [6:0]  hex_seg;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Three-flop resynchroniser for the divided scan clock; s3 only feeds the edge detect.
    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= scan_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

    // Digit 0 opens a frame and is decoded from the live inputs; later digits use the shadow.
    assign nib_src = (idx_q == 3'd0) ? data : shadow_q;
    assign dp_src  = (idx_q == 3'd0) ? dp   : dp_sh_q;
    assign nib     = nib_src[{idx_q, 2'b00} +: 4];
    assign dp_bit  = dp_src[idx_q];
    assign hex_seg = hex7(nib);
    assign idx_d   = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;

    // lz[i] is set when shadow nibbles i..DIGITS-1 are all zero.
    always_comb begin
        lz  = '0;
        acc = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < DIGITS) begin
                acc   = acc & (shadow_q[i*4 +: 4] == 4'h0);
                lz[i] = acc;
            end
        end
    end

    assign blank = BLANK_LZ && (idx_q != 3'd0) && lz[idx_q];

    // Digit scan: update the display on each tick, hold between ticks, park anodes when disabled.
    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= 3'd0;
            shadow_q     <= '0;
            dp_sh_q      <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!en) begin
                an_q <= AN_OFF;
            end else if (tick) begin
                if (idx_q == 3'd0) begin
                    shadow_q     <= data;
                    dp_sh_q      <= dp;
                    frame_done_q <= 1'b1;
                end
                an_q     <= AN_OFF ^ (8'd1 << idx_q);
                seg_q    <= blank ? SEG_OFF : (hex_seg ^ {7{ACTIVE_LOW}});
                seg_dp_q <= dp_bit ^ ACTIVE_LOW;
                idx_q    <= idx_d;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign frame_done = frame_done_q;

endmodule
